// File: rtl/lag_measure_ctrl.sv
// Input-lag measurement sequencer: times the photodiode response to each
// start trigger and accumulates per-series min/max/average latency.
module lag_measure_ctrl #(
  parameter int                   CNT_WIDTH      = 24,
  parameter int                   SAMPLES_LOG2   = 4,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT_CYCLES = 24'd8_000_000,
  parameter int                   DEBOUNCE       = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  starttrigger,
  input  logic                  sensor,
  output logic                  busy,
  output logic                  sample_valid,
  output logic [CNT_WIDTH-1:0]  sample_value,
  output logic [SAMPLES_LOG2:0] sample_index,
  output logic [7:0]            timeout_count,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  min_value,
  output logic [CNT_WIDTH-1:0]  max_value,
  output logic [CNT_WIDTH-1:0]  avg_value
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_MEASURE   = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int SUM_W = CNT_WIDTH + SAMPLES_LOG2;
  localparam int IDX_W = SAMPLES_LOG2 + 1;
  localparam int LAT_W = CNT_WIDTH + 1;
  localparam logic [IDX_W-1:0]     N_SAMPLES    = IDX_W'(1) << SAMPLES_LOG2;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - CNT_WIDTH'(1);

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_filt;
  logic                 r_filt_d;
  logic [DB_W-1:0]      r_db_cnt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [SUM_W-1:0]     r_sum;
  logic [CNT_WIDTH-1:0] r_min;
  logic [CNT_WIDTH-1:0] r_max;

  logic                 w_rise;
  logic [LAT_W-1:0]     w_lat_ext;
  logic [CNT_WIDTH-1:0] w_lat;

  // Sensor synchronizer and stability filter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1  <= sensor;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      if (r_sync2 == r_filt) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE - 1)) begin
        r_filt   <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Latency of a rise seen now, relative to the trigger cycle, minus path delay.
  always_comb begin
    w_rise    = r_filt & ~r_filt_d;
    w_lat_ext = {1'b0, r_cnt} + LAT_W'(1);
    if (w_lat_ext >= LAT_W'(DEBOUNCE + 2)) begin
      w_lat = CNT_WIDTH'(w_lat_ext - LAT_W'(DEBOUNCE + 2));
    end else begin
      w_lat = '0;
    end
  end

  // Series sequencer with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_sum         <= '0;
      r_min         <= '0;
      r_max         <= '0;
      busy          <= 1'b0;
      sample_valid  <= 1'b0;
      sample_value  <= '0;
      sample_index  <= '0;
      timeout_count <= 8'd0;
      done          <= 1'b0;
      min_value     <= '0;
      max_value     <= '0;
      avg_value     <= '0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state       <= S_ARM;
              busy          <= 1'b1;
              r_sum         <= '0;
              sample_index  <= '0;
              timeout_count <= 8'd0;
              r_min         <= '1;
              r_max         <= '0;
            end
          end
          S_ARM: begin
            if (!r_filt) begin
              r_state <= S_WAIT_TRIG;
            end
          end
          S_WAIT_TRIG: begin
            if (starttrigger) begin
              r_state <= S_MEASURE;
              r_cnt   <= '0;
            end
          end
          S_MEASURE: begin
            // A rise in the timeout cycle still counts as a sample.
            if (w_rise) begin
              sample_value <= w_lat;
              sample_valid <= 1'b1;
              r_sum        <= r_sum + SUM_W'(w_lat);
              if (w_lat < r_min) begin
                r_min <= w_lat;
              end
              if (w_lat > r_max) begin
                r_max <= w_lat;
              end
              sample_index <= sample_index + IDX_W'(1);
              if (sample_index + IDX_W'(1) == N_SAMPLES) begin
                r_state <= S_FINISH;
              end else begin
                r_state <= S_ARM;
              end
            end else if (r_cnt == TIMEOUT_LAST) begin
              if (timeout_count != 8'hFF) begin
                timeout_count <= timeout_count + 8'd1;
              end
              r_state <= S_ARM;
            end else begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
          S_FINISH: begin
            done      <= 1'b1;
            avg_value <= CNT_WIDTH'(r_sum >> SAMPLES_LOG2);
            min_value <= r_min;
            max_value <= r_max;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lag_measure_ctrl.sv
// Self-checking bench for lag_measure_ctrl: latencies are chosen by the bench
// and the expected sample/min/max/avg values follow directly from them.
module tb_lag_measure_ctrl;

  localparam int          CW = 24;
  localparam int          SL = 2;
  localparam int          DB = 4;
  localparam int          TO_INT = 2000;
  localparam logic [23:0] TO = 24'd2000;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic          starttrigger;
  logic          sensor;
  logic          busy;
  logic          sample_valid;
  logic [CW-1:0] sample_value;
  logic [SL:0]   sample_index;
  logic [7:0]    timeout_count;
  logic          done;
  logic [CW-1:0] min_value;
  logic [CW-1:0] max_value;
  logic [CW-1:0] avg_value;

  int n_checks = 0;
  int n_pass = 0;
  int valid_seen = 0;
  int done_seen = 0;
  int exp_min = 0;
  int exp_max = 0;
  int exp_avg = 0;
  int series_lat [4];

  lag_measure_ctrl #(
    .CNT_WIDTH(CW),
    .SAMPLES_LOG2(SL),
    .TIMEOUT_CYCLES(TO),
    .DEBOUNCE(DB)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .starttrigger(starttrigger),
    .sensor(sensor),
    .busy(busy),
    .sample_valid(sample_valid),
    .sample_value(sample_value),
    .sample_index(sample_index),
    .timeout_count(timeout_count),
    .done(done),
    .min_value(min_value),
    .max_value(max_value),
    .avg_value(avg_value)
  );

  always #5 clock = ~clock;

  // Pulse counters so scenarios can prove that no extra sample/done appeared.
  always @(posedge clock) begin
    if (sample_valid === 1'b1) valid_seen <= valid_seen + 1;
    if (done === 1'b1) done_seen <= done_seen + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Trigger now, light the sensor n cycles later, wait for sample_valid.
  task automatic measure(input int n, input bit retrig, output bit got);
    starttrigger = 1'b1;
    if (n == 0) sensor = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      starttrigger = (retrig && (i == n / 2)) ? 1'b1 : 1'b0;
      if (i == n) sensor = 1'b1;
    end
    tick();
    starttrigger = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (sample_valid === 1'b1) got = 1'b1;
      else tick();
    end
  endtask

  task automatic run_series(input bit lit);
    bit got;
    int mn, mx, sum, d0;
    if (lit) begin
      sensor = 1'b1;
      repeat (10) tick();
    end else begin
      sensor = 1'b0;
    end
    pulse_start();
    if (lit) begin
      for (int i = 1; i < 100; i++) begin
        starttrigger = (i == 40) ? 1'b1 : 1'b0;
        tick();
      end
      starttrigger = 1'b0;
      sensor = 1'b0;
    end
    repeat (12) tick();
    mn = 32'h7fff_ffff;
    mx = 0;
    sum = 0;
    d0 = done_seen;
    for (int k = 0; k < 4; k++) begin
      measure(series_lat[k], k == 2, got);
      n_checks++;
      if (!got) $display("FAIL series_valid_timeout[%0d]: got no sample_valid, expected one", k);
      else n_pass++;
      n_checks++;
      if (sample_value !== CW'(series_lat[k]))
        $display("FAIL series_value[%0d]: got %0d expected %0d", k, sample_value, series_lat[k]);
      else n_pass++;
      n_checks++;
      if (sample_index !== (SL+1)'(k + 1))
        $display("FAIL series_index[%0d]: got %0d expected %0d", k, sample_index, k + 1);
      else n_pass++;
      if (series_lat[k] < mn) mn = series_lat[k];
      if (series_lat[k] > mx) mx = series_lat[k];
      sum += series_lat[k];
      if (k < 3) begin
        sensor = 1'b0;
        if (k == 1) begin
          repeat (3) tick();
          pulse_start();
        end
        repeat (12) tick();
      end
    end
    tick();
    exp_min = mn;
    exp_max = mx;
    exp_avg = sum / 4;
    n_checks++;
    if (done !== 1'b1) $display("FAIL series_done: got %0b expected 1", done);
    else n_pass++;
    n_checks++;
    if (min_value !== CW'(exp_min) || max_value !== CW'(exp_max) || avg_value !== CW'(exp_avg))
      $display("FAIL series_results: got min=%0d max=%0d avg=%0d expected min=%0d max=%0d avg=%0d",
               min_value, max_value, avg_value, exp_min, exp_max, exp_avg);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL series_busy_end: got %0b expected 0", busy);
    else n_pass++;
    sensor = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (done_seen != d0 + 1) $display("FAIL series_done_count: got %0d expected %0d", done_seen - d0, 1);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    starttrigger = 1'b0;
    sensor = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({busy, sample_valid, done, sample_index, timeout_count} !== '0)
      $display("FAIL reset_ctrl: got busy=%0b valid=%0b done=%0b idx=%0d to=%0d expected all 0",
               busy, sample_valid, done, sample_index, timeout_count);
    else n_pass++;
    n_checks++;
    if ({sample_value, min_value, max_value, avg_value} !== '0)
      $display("FAIL reset_data: got val=%0d min=%0d max=%0d avg=%0d expected all 0",
               sample_value, min_value, max_value, avg_value);
    else n_pass++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    series_lat[0] = 1000;
    series_lat[1] = 1002;
    series_lat[2] = 1004;
    series_lat[3] = 1010;
    run_series(1'b1);
  endtask

  task automatic test_timeout();
    bit got;
    int n, v0;
    pulse_start();
    repeat (12) tick();
    n = $urandom_range(20, 1500);
    measure(n, 1'b0, got);
    n_checks++;
    if (!got || sample_value !== CW'(n))
      $display("FAIL timeout_pre_sample: got valid=%0b value=%0d expected valid=1 value=%0d", got, sample_value, n);
    else n_pass++;
    sensor = 1'b0;
    repeat (12) tick();
    v0 = valid_seen;
    starttrigger = 1'b1;
    tick();
    starttrigger = 1'b0;
    for (int i = 2; i <= TO_INT + 3; i++) begin
      if (i == TO_INT - 5) begin
        n_checks++;
        if (timeout_count !== 8'd0) $display("FAIL timeout_early: got %0d expected 0", timeout_count);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (timeout_count !== 8'd1) $display("FAIL timeout_count: got %0d expected 1", timeout_count);
    else n_pass++;
    n_checks++;
    if (sample_index !== 3'd1 || busy !== 1'b1 || valid_seen != v0)
      $display("FAIL timeout_state: got idx=%0d busy=%0b extra_valid=%0d expected idx=1 busy=1 extra_valid=0",
               sample_index, busy, valid_seen - v0);
    else n_pass++;
    n = $urandom_range(20, 1500);
    measure(n, 1'b0, got);
    n_checks++;
    if (!got || sample_value !== CW'(n) || sample_index !== 3'd2)
      $display("FAIL timeout_post_sample: got valid=%0b value=%0d idx=%0d expected valid=1 value=%0d idx=2",
               got, sample_value, sample_index, n);
    else n_pass++;
    sensor = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || sample_index !== 3'd2 || timeout_count !== 8'd1)
      $display("FAIL timeout_abort_hold: got busy=%0b idx=%0d to=%0d expected busy=0 idx=2 to=1",
               busy, sample_index, timeout_count);
    else n_pass++;
    repeat (12) tick();
  endtask

  task automatic test_glitch();
    bit got;
    int v0;
    pulse_start();
    repeat (12) tick();
    v0 = valid_seen;
    starttrigger = 1'b1;
    for (int i = 1; i <= 500; i++) begin
      tick();
      starttrigger = 1'b0;
      if (i == 100) sensor = 1'b1;
      else if (i == 100 + DB - 1) sensor = 1'b0;
      if (i == 500) sensor = 1'b1;
    end
    tick();
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (sample_valid === 1'b1) got = 1'b1;
      else tick();
    end
    n_checks++;
    if (!got || sample_value !== 24'd500 || sample_index !== 3'd1)
      $display("FAIL glitch_sample: got valid=%0b value=%0d idx=%0d expected valid=1 value=500 idx=1",
               got, sample_value, sample_index);
    else n_pass++;
    tick();
    n_checks++;
    if (valid_seen != v0 + 1) $display("FAIL glitch_count: got %0d samples expected 1", valid_seen - v0);
    else n_pass++;
    // Sensor lights two cycles before the trigger: latency saturates at 0.
    sensor = 1'b0;
    repeat (12) tick();
    sensor = 1'b1;
    tick();
    tick();
    starttrigger = 1'b1;
    tick();
    starttrigger = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (sample_valid === 1'b1) got = 1'b1;
      else tick();
    end
    n_checks++;
    if (!got || sample_value !== 24'd0 || sample_index !== 3'd2)
      $display("FAIL saturate_zero: got valid=%0b value=%0d idx=%0d expected valid=1 value=0 idx=2",
               got, sample_value, sample_index);
    else n_pass++;
    sensor = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_abort();
    bit got;
    int n, d0;
    pulse_start();
    repeat (12) tick();
    n = $urandom_range(20, 1500);
    measure(n, 1'b0, got);
    n_checks++;
    if (!got || sample_value !== CW'(n))
      $display("FAIL abort_pre_sample: got valid=%0b value=%0d expected valid=1 value=%0d", got, sample_value, n);
    else n_pass++;
    sensor = 1'b0;
    repeat (12) tick();
    starttrigger = 1'b1;
    tick();
    starttrigger = 1'b0;
    repeat (50) tick();
    d0 = done_seen;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %0b expected 0", busy);
    else n_pass++;
    repeat (20) tick();
    n_checks++;
    if (done_seen != d0 || sample_index !== 3'd1)
      $display("FAIL abort_no_done: got done_pulses=%0d idx=%0d expected done_pulses=0 idx=1",
               done_seen - d0, sample_index);
    else n_pass++;
    n_checks++;
    if (min_value !== CW'(exp_min) || max_value !== CW'(exp_max) || avg_value !== CW'(exp_avg))
      $display("FAIL abort_results_held: got min=%0d max=%0d avg=%0d expected min=%0d max=%0d avg=%0d",
               min_value, max_value, avg_value, exp_min, exp_max, exp_avg);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) series_lat[k] = $urandom_range(20, 1500);
      if (s == 0) series_lat[0] = 0;
      run_series(1'b0);
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    repeat (12) tick();
    starttrigger = 1'b1;
    tick();
    starttrigger = 1'b0;
    repeat (30) tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, sample_valid, done, sample_index, timeout_count} !== '0)
      $display("FAIL midreset_ctrl: got busy=%0b idx=%0d to=%0d expected all 0", busy, sample_index, timeout_count);
    else n_pass++;
    n_checks++;
    if ({sample_value, min_value, max_value, avg_value} !== '0)
      $display("FAIL midreset_data: got val=%0d min=%0d max=%0d avg=%0d expected all 0",
               sample_value, min_value, max_value, avg_value);
    else n_pass++;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_glitch();
    test_abort();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lag_measure_ctrl.md
# lag_measure_ctrl

Sequences input-lag measurement series for the lag tester. It watches the one-cycle start trigger that the video timing generator emits when the white measurement fields switch on, then times the photodiode sensor's response. It collects a fixed number of valid samples, discarding timeouts, and reports per-sample latency plus min/max/average for the series. It sits between the video timing generator and the result/OSD logic, in the pixel clock domain.

## Interface
- CNT_WIDTH, 24: width of latency counter and per-sample/min/max/avg results.
- SAMPLES_LOG2, 4: series length is 2^SAMPLES_LOG2 valid samples.
- TIMEOUT_CYCLES, 24'd8_000_000: a measurement aborts after this many cycles without a sensor response.
- DEBOUNCE, 4: cycles the synchronized sensor must be stable before the filtered value changes (≥1).
- clock  in  1  pixel clock, shared with the video timing generator.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a series; ignored unless idle.
- abort  in  1  level, stops any series.
- starttrigger  in  1  one-cycle pulse, fields just switched on.
- sensor  in  1  raw asynchronous photodiode comparator; 1 = light.
- busy  out  1  high in every state except IDLE.
- sample_valid  out  1  one-cycle pulse with sample_value.
- sample_value  out  CNT_WIDTH  latency of the last valid sample, in cycles.
- sample_index  out  SAMPLES_LOG2+1  count of valid samples in the current series.
- timeout_count  out  8  timeouts in the current series, saturating at 255.
- done  out  1  one-cycle pulse when the series completes.
- min_value, max_value, avg_value  out  CNT_WIDTH each  series results, updated only at done.

## Operation
- Sensor path: 2-flop synchronizer, then a stability filter. sensor_filt takes the synchronized value after DEBOUNCE consecutive equal samples. Total path latency is DEBOUNCE+2 cycles.
- States: IDLE, ARM, WAIT_TRIG, MEASURE, FINISH.
- IDLE: start → ARM. At that transition:
  - clear sum, sample_index and timeout_count;
  - set internal min to all-ones and internal max to 0.
- ARM: sensor_filt==0 → WAIT_TRIG. starttrigger is ignored here.
- WAIT_TRIG: starttrigger → MEASURE; the latency counter loads 0.
- MEASURE: the counter increments every cycle.
  - sensor_filt rising, i.e. 0 the previous cycle and 1 now, records a sample and moves to FINISH if sample_index reaches 2^SAMPLES_LOG2, else to ARM.
  - Recording a sample means:
    - sample_value = counter − (DEBOUNCE+2), saturating at 0;
    - pulse sample_valid;
    - add sample_value to sum, update min/max;
    - sample_index++.
  - counter == TIMEOUT_CYCLES−1 without a rise: timeout_count++ (saturating) → ARM; no sample is recorded.
- FINISH: for one cycle:
  - pulse done;
  - avg_value = sum >> SAMPLES_LOG2 (truncate);
  - min_value/max_value ← internal min/max;
  - → IDLE.
- Arithmetic: sum is CNT_WIDTH+SAMPLES_LOG2 bits wide and cannot overflow; the counter does not wrap, because timeout precedes the maximum count.
- abort high in any state → IDLE next cycle.
  - No done pulse.
  - Result outputs keep their previous values.
  - sample_index and timeout_count hold until the next start.

## Timing
- Reset: every output 0, state IDLE, filter and synchronizers 0.
- The latency reference is the cycle in which starttrigger is high: a sensor edge that is stable at the clock edge ending trigger cycle + N yields sample_value = N.
- sample_valid asserts on the cycle after the filtered rise is detected; sample_value/sample_index are valid from that cycle and held until the next sample.
- done asserts 1 cycle after the final sample_valid; min/max/avg are valid from the done cycle.
- Simultaneous events:
  - abort together with any event: abort wins.
  - sensor rise together with timeout in the same cycle: the sample wins.
  - start while busy: ignored.
  - starttrigger in MEASURE: ignored; the counter is not restarted.
- sensor already lit when ARM is entered: the block waits in ARM until dark, so sample N+1 always uses a fresh trigger.
- Mid-series reset: immediate return to reset values; no done.

## Test plan
- SAMPLES_LOG2=2, DEBOUNCE=4; sensor goes dark 100 cycles after start. Four triggers, with the sensor rising 1000, 1002, 1004, 1010 cycles after each trigger → four sample_valid pulses with those values; done; min=1000, max=1010, avg=1004.
- No sensor rise after a trigger → timeout_count=1 after TIMEOUT_CYCLES; the state returns to ARM; sample_index is unchanged; the next trigger is measured normally.
- Glitch of DEBOUNCE−1 cycles on sensor during MEASURE → no sample; a later stable rise at N=500 → sample_value=500.
- Sensor held lit at start → stays in ARM; triggers are ignored until dark; then normal measurement.
- abort asserted mid-MEASURE → busy=0 next cycle, no done, results unchanged; a following start measures a clean series.
- reset_n pulsed low mid-series → all outputs 0 immediately; start after release behaves as the first scenario.
